// File: rtl/att_dot_pkg.sv
// rtl/att_dot_pkg.sv - shared types and constants for the attention dot-product engine
// Purpose: opcode and FSM enums, engine configuration record, SETUP decode limits.
// Ports: none (package).
package att_dot_pkg;

    // SETUP encodes K=256 as 0 in an 8-bit field
    localparam int ATT_SETUP_K_MAX = 256;

    // Q8.8 value of 1.0, the scale after reset
    localparam logic signed [15:0] ATT_SCALE_UNITY = 16'sh0100;

    typedef enum logic [1:0] {
        ATT_SETUP     = 2'd0,
        ATT_RUN       = 2'd1,
        ATT_RUN_SCALE = 2'd2,
        ATT_RUN_CLIP  = 2'd3
    } att_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STAGE   = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_POST    = 3'd3,
        ST_RESP    = 3'd4
    } att_state_e;

    typedef struct packed {
        logic [7:0]         k_words;
        logic signed [15:0] scale;
        logic [3:0]         shift;
        logic               valid;
    } att_cfg_t;

endpackage

// File: rtl/att_dot_reduce_tree.sv
// rtl/att_dot_reduce_tree.sv - combinational WPC*4 INT8 product and adder tree
// Purpose: multiply WPC packed Q/K word pairs bytewise (signed INT8) and sum all
//          products into one ACC_W signed value; masked-off words contribute 0.
// Ports:
//   i_q    in  WPC*32  packed Q words, word j at [j*32 +: 32]
//   i_k    in  WPC*32  packed K words, same layout
//   i_mask in  WPC     1 = word j takes part in the sum
//   o_sum  out ACC_W   signed sum of the enabled products
module att_dot_reduce_tree #(
    parameter int WPC   = 2,
    parameter int ACC_W = 32
) (
    input  logic [WPC*32-1:0] i_q,
    input  logic [WPC*32-1:0] i_k,
    input  logic [WPC-1:0]    i_mask,
    output logic [ACC_W-1:0]  o_sum
);

    logic signed [15:0]      w_p;
    logic signed [ACC_W-1:0] w_acc;

    always_comb begin
        w_p   = '0;
        w_acc = '0;
        for (int j = 0; j < WPC; j++) begin
            for (int b = 0; b < 4; b++) begin
                w_p = 16'($signed(i_q[j*32 + b*8 +: 8])) * 16'($signed(i_k[j*32 + b*8 +: 8]));
                if (i_mask[j]) begin
                    w_acc = w_acc + ACC_W'(w_p);
                end
            end
        end
    end

    assign o_sum = w_acc;

endmodule

// File: rtl/att_dot_mlane_engine.sv
// rtl/att_dot_mlane_engine.sv - multi-lane INT8 attention dot-product coprocessor engine
// Purpose: SETUP configures K/scale/shift; RUN/RUN_SCALE/RUN_CLIP stage Q/K words,
//          then WPC words per cycle are reduced into a signed accumulator, followed by
//          an optional Q8.8 scale/shift with saturation and a clamp.
// Build option: GARUDA_ATT_ROUND_EN adds 1<<(7+shift) before the shift (round half up)
//          for RUN_SCALE/RUN_CLIP; undefined gives a floor shift.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   issue_valid_i/issue_ready_o    instruction handshake
//   issue_op_i [1:0]               SETUP/RUN/RUN_SCALE/RUN_CLIP
//   issue_rs1_i/issue_rs2_i [31:0] SETUP: K, shift / scale; RUN*: Q word / K word
//   issue_rd_i [4:0]               destination register id
//   res_valid_o/res_ready_i        result handshake
//   res_data_o [ACC_W-1:0]         result value
//   res_rd_o [4:0]                 destination register id echo
//   res_done_o                     1 = final dot result, 0 = staging acknowledge
//   res_err_o                      1 = rejected (unconfigured / bad K)
module att_dot_mlane_engine #(
    parameter int MAX_K    = 256,
    parameter int WPC      = 2,
    parameter int ACC_W    = 32,
    parameter int CLIP_MIN = -32768,
    parameter int CLIP_MAX = 32767
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [1:0]       issue_op_i,
    input  logic [31:0]      issue_rs1_i,
    input  logic [31:0]      issue_rs2_i,
    input  logic [4:0]       issue_rd_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [ACC_W-1:0] res_data_o,
    output logic [4:0]       res_rd_o,
    output logic             res_done_o,
    output logic             res_err_o
);

    import att_dot_pkg::*;

    localparam int DEPTH = MAX_K / 4;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW    = ACC_W + 16;
    localparam logic signed [ACC_W-1:0] W_CLIP_MIN = ACC_W'(CLIP_MIN);
    localparam logic signed [ACC_W-1:0] W_CLIP_MAX = ACC_W'(CLIP_MAX);

    att_state_e              r_state, w_state_nxt;
    att_cfg_t                r_cfg;
    att_op_e                 r_op;
    logic [IW-1:0]           r_idx;
    logic [31:0]             r_q_mem [DEPTH];
    logic [31:0]             r_k_mem [DEPTH];
    logic signed [ACC_W-1:0] r_acc;
    logic signed [PW-1:0]    r_prod;
    logic                    r_res_valid;
    logic [ACC_W-1:0]        r_res_data;
    logic [4:0]              r_res_rd;
    logic                    r_res_done;
    logic                    r_res_err;

    att_op_e                 w_op;
    logic                    w_issue_fire;
    logic                    w_res_fire;
    logic                    w_last_word;
    logic                    w_cmp_last;
    logic [8:0]              w_setup_k;
    logic                    w_setup_ok;
    logic [WPC*32-1:0]       w_q_vec;
    logic [WPC*32-1:0]       w_k_vec;
    logic [WPC-1:0]          w_mask;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [PW-1:0]    w_prod;
    logic signed [PW-1:0]    w_round;
    logic signed [PW-1:0]    w_shifted;
    logic [4:0]              w_shamt;
    logic signed [ACC_W-1:0] w_sat;
    logic signed [ACC_W-1:0] w_clip;
    logic signed [ACC_W-1:0] w_post;

    assign w_op          = att_op_e'(issue_op_i);
    assign issue_ready_o = ((r_state == ST_IDLE) || (r_state == ST_STAGE)) && !r_res_valid;
    assign w_issue_fire  = issue_valid_i && issue_ready_o;
    assign w_res_fire    = r_res_valid && res_ready_i;
    assign w_last_word   = (32'(r_idx) == (32'(r_cfg.k_words) - 32'd1));
    assign w_cmp_last    = ((32'(r_idx) + 32'(WPC)) >= 32'(r_cfg.k_words));

    assign w_setup_k  = (issue_rs1_i[7:0] == 8'd0) ? 9'(ATT_SETUP_K_MAX) : {1'b0, issue_rs1_i[7:0]};
    assign w_setup_ok = (w_setup_k[1:0] == 2'b00) && (32'(w_setup_k) <= 32'(MAX_K));

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_STAGE: begin
                if (w_issue_fire) begin
                    if (w_op == ATT_SETUP) begin
                        // SETUP mid-staging abandons the partial dot
                        w_state_nxt = ST_IDLE;
                    end else if (r_cfg.valid) begin
                        w_state_nxt = w_last_word ? ST_COMPUTE : ST_STAGE;
                    end
                end
            end
            ST_COMPUTE: if (w_cmp_last) w_state_nxt = ST_POST;
            ST_POST:    w_state_nxt = ST_RESP;
            ST_RESP:    if (w_res_fire) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Staging storage holds no reset: the word index alone says what is live
    always_ff @(posedge clk_i) begin
        if (w_issue_fire && (w_op != ATT_SETUP) && r_cfg.valid) begin
            r_q_mem[r_idx] <= issue_rs1_i;
            r_k_mem[r_idx] <= issue_rs2_i;
        end
    end

    // Gather the WPC words starting at the compute index; words past K/4 are masked
    always_comb begin
        w_q_vec = '0;
        w_k_vec = '0;
        w_mask  = '0;
        for (int j = 0; j < WPC; j++) begin
            w_q_vec[j*32 +: 32] = r_q_mem[r_idx + IW'(j)];
            w_k_vec[j*32 +: 32] = r_k_mem[r_idx + IW'(j)];
            w_mask[j]           = (32'(r_idx) + 32'(j)) < 32'(r_cfg.k_words);
        end
    end

    att_dot_reduce_tree #(
        .WPC   (WPC),
        .ACC_W (ACC_W)
    ) u_reduce (
        .i_q    (w_q_vec),
        .i_k    (w_k_vec),
        .i_mask (w_mask),
        .o_sum  (w_sum)
    );

    // Post-op: the wide product is registered in POST, shift/saturate/clamp in RESP
    assign w_prod  = PW'(r_acc) * PW'($signed(r_cfg.scale));
    assign w_shamt = 5'd8 + 5'(r_cfg.shift);
`ifdef GARUDA_ATT_ROUND_EN
    assign w_round = PW'(1) <<< (w_shamt - 5'd1);
`else
    assign w_round = '0;
`endif
    assign w_shifted = (r_prod + w_round) >>> w_shamt;

    always_comb begin
        w_sat = w_shifted[ACC_W-1:0];
        // Out of range when the bits above the ACC_W sign bit are not all copies of it
        if (!((&w_shifted[PW-1:ACC_W-1]) || (~|w_shifted[PW-1:ACC_W-1]))) begin
            w_sat = w_shifted[PW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        w_clip = w_sat;
        if (w_sat < W_CLIP_MIN) begin
            w_clip = W_CLIP_MIN;
        end else if (w_sat > W_CLIP_MAX) begin
            w_clip = W_CLIP_MAX;
        end
        case (r_op)
            ATT_RUN_SCALE: w_post = w_sat;
            ATT_RUN_CLIP:  w_post = w_clip;
            default:       w_post = r_acc;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cfg       <= '{k_words: '0, scale: ATT_SCALE_UNITY, shift: '0, valid: 1'b0};
            r_op        <= ATT_RUN;
            r_idx       <= '0;
            r_acc       <= '0;
            r_prod      <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_rd    <= '0;
            r_res_done  <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            if (w_res_fire) begin
                r_res_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE, ST_STAGE: begin
                    if (w_issue_fire) begin
                        if (w_op == ATT_SETUP) begin
                            r_cfg.k_words <= {1'b0, w_setup_k[8:2]};
                            r_cfg.scale   <= $signed(issue_rs2_i[15:0]);
                            r_cfg.shift   <= issue_rs1_i[11:8];
                            r_cfg.valid   <= w_setup_ok;
                            r_idx         <= '0;
                        end else begin
                            r_res_rd <= issue_rd_i;
                            if (!r_cfg.valid) begin
                                r_res_valid <= 1'b1;
                                r_res_data  <= '0;
                                r_res_done  <= 1'b0;
                                r_res_err   <= 1'b1;
                            end else if (w_last_word) begin
                                r_idx <= '0;
                                r_op  <= w_op;
                                r_acc <= '0;
                            end else begin
                                r_idx       <= r_idx + IW'(1);
                                r_res_valid <= 1'b1;
                                r_res_data  <= '0;
                                r_res_done  <= 1'b0;
                                r_res_err   <= 1'b0;
                            end
                        end
                    end
                end
                ST_COMPUTE: begin
                    r_acc <= r_acc + w_sum;
                    r_idx <= w_cmp_last ? '0 : r_idx + IW'(WPC);
                end
                ST_POST: begin
                    r_prod <= w_prod;
                end
                ST_RESP: begin
                    if (!r_res_valid) begin
                        r_res_valid <= 1'b1;
                        r_res_data  <= w_post;
                        r_res_done  <= 1'b1;
                        r_res_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid_o = r_res_valid;
    assign res_data_o  = r_res_data;
    assign res_rd_o    = r_res_rd;
    assign res_done_o  = r_res_done;
    assign res_err_o   = r_res_err;

endmodule

// File: tb/tb_att_dot_mlane_engine.sv
// tb/tb_att_dot_mlane_engine.sv - self-checking bench for att_dot_mlane_engine
module tb_att_dot_mlane_engine;

    localparam int MAX_K = 256;
    localparam int WPC   = 2;
    localparam int ACC_W = 32;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [1:0]  issue_op_i;
    logic [31:0] issue_rs1_i;
    logic [31:0] issue_rs2_i;
    logic [4:0]  issue_rd_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] res_data_o;
    logic [4:0]  res_rd_o;
    logic        res_done_o;
    logic        res_err_o;

    int checks = 0;
    int errors = 0;
    bit [31:0] qv [64];
    bit [31:0] kv [64];

    always #5 clk_i = ~clk_i;

    att_dot_mlane_engine #(
        .MAX_K    (MAX_K),
        .WPC      (WPC),
        .ACC_W    (ACC_W),
        .CLIP_MIN (-32768),
        .CLIP_MAX (32767)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .issue_op_i    (issue_op_i),
        .issue_rs1_i   (issue_rs1_i),
        .issue_rs2_i   (issue_rs2_i),
        .issue_rd_i    (issue_rd_i),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .res_data_o    (res_data_o),
        .res_rd_o      (res_rd_o),
        .res_done_o    (res_done_o),
        .res_err_o     (res_err_o)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h (%0d) expected 0x%0h (%0d)", tag, obs, $signed(obs), exp, $signed(exp));
        end
    endtask

    // Reference: dot product of the first nw word pairs, then scale/floor-divide,
    // saturate to 32 bits and optionally clamp, all in plain 64-bit arithmetic.
    function automatic longint model(input int op, input int nw, input int scale_raw, input int shift);
        longint acc, p, d, r;
        int     s;
        bit [31:0] qw, kw;
        byte    qb, kb;
        acc = 0;
        for (int w = 0; w < nw; w++) begin
            qw = qv[w];
            kw = kv[w];
            for (int b = 0; b < 4; b++) begin
                qb = qw[b*8 +: 8];
                kb = kw[b*8 +: 8];
                acc = acc + longint'(qb) * longint'(kb);
            end
        end
        if (op == 1) return acc;
        s = (scale_raw >= 32768) ? scale_raw - 65536 : scale_raw;
        p = acc * longint'(s);
        d = longint'(1) << (8 + shift);
`ifdef GARUDA_ATT_ROUND_EN
        p = p + d / 2;
`endif
        r = p / d;
        if ((p % d != 0) && (p < 0)) r = r - 1;
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
        if (op == 3) begin
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
        end
        return r;
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge
    task automatic issue(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] rd);
        int n;
        n = 0;
        issue_valid_i = 1'b1;
        issue_op_i    = op;
        issue_rs1_i   = rs1;
        issue_rs2_i   = rs2;
        issue_rd_i    = rd;
        while (!issue_ready_o && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("issue_wait_in_bound", 32'(n < 200), 32'd1);
        @(posedge clk_i); #1;
        issue_valid_i = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [31:0] exp_data, input logic exp_done,
                              input logic exp_err, input logic [4:0] exp_rd, output int lat);
        lat = 0;
        while (res_valid_o !== 1'b1 && lat < 300) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check({tag, "_valid"}, 32'(res_valid_o), 32'd1);
        check({tag, "_data"}, res_data_o, exp_data);
        check({tag, "_done"}, 32'(res_done_o), 32'(exp_done));
        check({tag, "_err"}, 32'(res_err_o), 32'(exp_err));
        check({tag, "_rd"}, 32'(res_rd_o), 32'(exp_rd));
        @(posedge clk_i); #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_issue_ready"}, 32'(issue_ready_o), 32'd1);
        check({tag, "_res_valid"}, 32'(res_valid_o), 32'd0);
        check({tag, "_res_data"}, res_data_o, 32'd0);
        check({tag, "_res_rd"}, 32'(res_rd_o), 32'd0);
        check({tag, "_res_done"}, 32'(res_done_o), 32'd0);
        check({tag, "_res_err"}, 32'(res_err_o), 32'd0);
    endtask

    task automatic setup(input int kel, input int scale_raw, input int shift);
        issue(2'd0, {20'd0, 4'(shift), 8'(kel)}, {16'd0, 16'(scale_raw)}, 5'd0);
    endtask

    task automatic run_dot(input string tag, input int op, input int kel, input int scale_raw,
                           input int shift);
        int        nw;
        int        lat;
        logic [4:0] rd;
        longint    exp;
        nw  = kel / 4;
        exp = model(op, nw, scale_raw, shift);
        setup(kel, scale_raw, shift);
        for (int w = 0; w < nw; w++) begin
            rd = 5'($urandom);
            issue(2'(op), qv[w], kv[w], rd);
            if (w < nw - 1) begin
                get_result({tag, "_ack"}, 32'd0, 1'b0, 1'b0, rd, lat);
                check({tag, "_ack_latency"}, 32'(lat), 32'd0);
            end else begin
                get_result({tag, "_final"}, exp[31:0], 1'b1, 1'b0, rd, lat);
                check({tag, "_final_latency"}, 32'(lat), 32'((nw + WPC - 1) / WPC + 2));
            end
        end
    endtask

    initial begin
        int     lat;
        longint exp;
        issue_valid_i = 1'b0;
        issue_op_i    = '0;
        issue_rs1_i   = '0;
        issue_rs2_i   = '0;
        issue_rd_i    = '0;
        res_ready_i   = 1'b1;
        rst_ni        = 1'b0;

        // Reset values
        repeat (3) @(posedge clk_i);
        #1;
        check_reset("reset");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Unconfigured after reset: RUN rejected
        issue(2'd1, 32'h01010101, 32'h01010101, 5'd3);
        get_result("unconfigured", 32'd0, 1'b0, 1'b1, 5'd3, lat);

        // Plain RUN, K=8
        qv[0] = 32'h01010101; qv[1] = 32'h01010101;
        kv[0] = 32'h02020202; kv[1] = 32'h02020202;
        run_dot("run_k8", 1, 8, 16'h0100, 0);

        // RUN_SCALE, scale 0.5, shift 1
        run_dot("scale_k8", 2, 8, 16'h0080, 1);

        // RUN_CLIP at K=256 (SETUP K field 0)
        for (int w = 0; w < 64; w++) begin
            qv[w] = 32'h7F7F7F7F;
            kv[w] = 32'h7F7F7F7F;
        end
        run_dot("clip_k256", 3, 256, 16'h0100, 0);

        // Most negative products, result held under backpressure
        setup(4, 16'h0100, 0);
        qv[0] = 32'h80808080;
        kv[0] = 32'h7F7F7F7F;
        exp = model(1, 1, 16'h0100, 0);
        res_ready_i = 1'b0;
        issue(2'd1, qv[0], kv[0], 5'd9);
        lat = 0;
        while (res_valid_o !== 1'b1 && lat < 300) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check("hold_latency", 32'(lat), 32'd3);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            check("hold_valid", 32'(res_valid_o), 32'd1);
            check("hold_data", res_data_o, exp[31:0]);
            check("hold_rd", 32'(res_rd_o), 32'd9);
            check("hold_issue_ready", 32'(issue_ready_o), 32'd0);
        end
        res_ready_i = 1'b1;
        get_result("hold_final", exp[31:0], 1'b1, 1'b0, 5'd9, lat);
        check("hold_released", 32'(res_valid_o), 32'd0);

        // K not a multiple of 4 is rejected
        setup(6, 16'h0100, 0);
        issue(2'd1, 32'h11111111, 32'h11111111, 5'd7);
        get_result("bad_k6", 32'd0, 1'b0, 1'b1, 5'd7, lat);

        // SETUP mid-staging aborts, next RUN is a fresh one-word dot
        setup(8, 16'h0100, 0);
        issue(2'd1, 32'h05050505, 32'h05050505, 5'd4);
        get_result("abort_ack", 32'd0, 1'b0, 1'b0, 5'd4, lat);
        qv[0] = $urandom;
        kv[0] = $urandom;
        run_dot("abort_fresh", 1, 4, 16'h0100, 0);

        // Randomized dots
        for (int it = 0; it < 10; it++) begin
            int kel, op, sc, sh;
            kel = 4 * $urandom_range(1, 16);
            op  = $urandom_range(1, 3);
            sc  = $urandom_range(0, 65535);
            sh  = $urandom_range(0, 15);
            for (int w = 0; w < 64; w++) begin
                qv[w] = $urandom;
                kv[w] = $urandom;
            end
            run_dot($sformatf("rand%0d", it), op, kel, sc, sh);
        end

        // Reset asserted during COMPUTE
        setup(0, 16'h0100, 0);
        for (int w = 0; w < 64; w++) begin
            issue(2'd1, 32'h7F7F7F7F, 32'h7F7F7F7F, 5'd1);
            if (w < 63) get_result("pre_reset_ack", 32'd0, 1'b0, 1'b0, 5'd1, lat);
        end
        repeat (5) @(posedge clk_i);
        #1;
        check("in_compute_issue_ready", 32'(issue_ready_o), 32'd0);
        rst_ni = 1'b0;
        #1;
        check_reset("mid_reset");
        repeat (2) @(posedge clk_i);
        #1;
        check_reset("mid_reset_held");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("post_reset_no_result", 32'(res_valid_o), 32'd0);
        issue(2'd1, 32'h01010101, 32'h01010101, 5'd2);
        get_result("post_reset_unconfigured", 32'd0, 1'b0, 1'b1, 5'd2, lat);
        qv[0] = $urandom;
        kv[0] = $urandom;
        run_dot("post_reset_k4", 2, 4, 16'h0100, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
